fifo_wr_arb: RTL and testbench

FIFO_WR_ARB -- requirements
Module: fifo_wr_arb

---
 rtl/fifo_wr_arb_pkg.sv | 22 ++
 rtl/fifo_wr_arb_rr_pick.sv | 38 +++
 rtl/fifo_wr_arb.sv | 173 +++++++++++++++++
 tb/tb_fifo_wr_arb.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_wr_arb_pkg.sv
// rtl/fifo_wr_arb_pkg.sv - shared types and defaults for the FIFO write-port arbiter
//
// Holds the FSM state encoding, the default parameter values and a small
// modulo-increment helper used for the round-robin pointer.
// No ports (package).
package fifo_wr_arb_pkg;

  localparam int NREQ_DEF      = 4;
  localparam int DW_DEF        = 8;
  localparam int DEPTH_DEF     = 8;
  localparam int BURST_LEN_DEF = 4;

  typedef logic [0:0] state_t;
  localparam state_t IDLE  = 1'b0;
  localparam state_t BURST = 1'b1;

  // (idx + 1) mod n, for idx already in 0..n-1
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/fifo_wr_arb_rr_pick.sv
// rtl/fifo_wr_arb_rr_pick.sv - combinational round-robin picker
//
// Finds the first asserted request at or above ptr, wrapping NREQ-1 -> 0.
// Ports:
//   req  in  [NREQ-1:0]          request vector
//   ptr  in  [$clog2(NREQ)-1:0]  highest-priority index
//   gnt  out [NREQ-1:0]          one-hot pick (zero when no request)
//   idx  out [$clog2(NREQ)-1:0]  index of the pick
//   vld  out                     a request was found
module rr_pick #(
  parameter int NREQ = 4
) (
  input  logic [NREQ-1:0]         req,
  input  logic [$clog2(NREQ)-1:0] ptr,
  output logic [NREQ-1:0]         gnt,
  output logic [$clog2(NREQ)-1:0] idx,
  output logic                    vld
);

  int k;

  always_comb begin
    gnt = '0;
    idx = '0;
    vld = 1'b0;
    k   = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr) + i;
      if (k >= NREQ) k = k - NREQ;
      if (!vld && req[k]) begin
        vld    = 1'b1;
        gnt[k] = 1'b1;
        idx    = k[$clog2(NREQ)-1:0];
      end
    end
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - credit-based round-robin burst arbiter for a shared FIFO write port
//
// Optional feature: define FIFO_WR_ARB_GNT_CNT_EN to add per-requester
// saturating 16-bit transfer counters on gnt_cnt.
// Ports:
//   clk       in   single clock, rising edge
//   reset     in   asynchronous active-high reset
//   req       in   [NREQ-1:0]     per-requester write request
//   din       in   [NREQ*DW-1:0]  requester i data at [i*DW +: DW]
//   gnt       out  [NREQ-1:0]     combinational one-hot grant
//   fifo_pop  in   FIFO reader removed one entry
//   fifo_wen  out  registered FIFO write enable
//   fifo_din  out  [DW-1:0]       registered FIFO write data
//   fifo_src  out  [$clog2(NREQ)-1:0] requester that supplied fifo_din
//   gnt_cnt   out  [NREQ*16-1:0]  transfer counters (FIFO_WR_ARB_GNT_CNT_EN only)
module fifo_wr_arb
  import fifo_wr_arb_pkg::*;
#(
  parameter int NREQ      = NREQ_DEF,
  parameter int DW        = DW_DEF,
  parameter int DEPTH     = DEPTH_DEF,
  parameter int BURST_LEN = BURST_LEN_DEF
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*DW-1:0]      din,
  output logic [NREQ-1:0]         gnt,
  input  logic                    fifo_pop,
  output logic                    fifo_wen,
  output logic [DW-1:0]           fifo_din,
  output logic [$clog2(NREQ)-1:0] fifo_src
`ifdef FIFO_WR_ARB_GNT_CNT_EN
  ,
  output logic [NREQ*16-1:0]      gnt_cnt
`endif
);

  localparam int IW = $clog2(NREQ);
  localparam int CW = $clog2(DEPTH + 1);
  localparam int BW = $clog2(BURST_LEN + 1);
  localparam logic [CW-1:0] CREDIT_MAX = CW'(DEPTH);
  localparam logic [BW-1:0] BEAT_MAX   = BW'(BURST_LEN);

  state_t          state_q, state_d;
  logic [IW-1:0]   ptr_q, ptr_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [BW-1:0]   beat_q, beat_d;
  logic [CW-1:0]   credit_q, credit_d;
  logic            fifo_wen_q, fifo_wen_d;
  logic [DW-1:0]   fifo_din_q, fifo_din_d;
  logic [IW-1:0]   fifo_src_q, fifo_src_d;

  logic [NREQ-1:0] pick_gnt;
  logic [IW-1:0]   pick_idx;
  logic            pick_vld;
  logic            credit_avail;
  logic            xfer;
  logic            pop_eff;
  logic [IW-1:0]   xfer_idx;
  logic [DW-1:0]   xfer_data;

  rr_pick #(.NREQ(NREQ)) u_rr_pick (
    .req (req),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx),
    .vld (pick_vld)
  );

  assign credit_avail = (credit_q != '0);

  // Grant and FSM next state. A burst ends with one grant-free release
  // cycle, which is what leaves a gap between consecutive owners.
  always_comb begin
    gnt      = '0;
    xfer_idx = owner_q;
    state_d  = state_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    beat_d   = beat_q;
    if (!reset) begin
      case (state_q)
        IDLE: begin
          if (credit_avail && pick_vld) begin
            gnt      = pick_gnt;
            xfer_idx = pick_idx;
            owner_d  = pick_idx;
            beat_d   = BW'(1);
            if (BURST_LEN > 1) state_d = BURST;
            else               ptr_d   = IW'(wrap_inc(int'(pick_idx), NREQ));
          end
        end
        default: begin
          if (beat_q == BEAT_MAX || !req[owner_q]) begin
            state_d = IDLE;
            ptr_d   = IW'(wrap_inc(int'(owner_q), NREQ));
          end else if (credit_avail) begin
            gnt[owner_q] = 1'b1;
            beat_d       = beat_q + BW'(1);
          end
          // else: stalled on credit, owner and beat held
        end
      endcase
    end
  end

  assign xfer = |(req & gnt);

  // A pop against an empty FIFO cannot free an entry.
  assign pop_eff = fifo_pop && (credit_q != CREDIT_MAX);

  always_comb begin
    xfer_data = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (int'(xfer_idx) == i) xfer_data = din[i*DW +: DW];
    end
  end

  always_comb begin
    credit_d = credit_q;
    if (xfer && !pop_eff)      credit_d = credit_q - CW'(1);
    else if (!xfer && pop_eff) credit_d = credit_q + CW'(1);
    fifo_wen_d = xfer;
    fifo_din_d = xfer ? xfer_data : fifo_din_q;
    fifo_src_d = xfer ? xfer_idx  : fifo_src_q;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      ptr_q      <= '0;
      owner_q    <= '0;
      beat_q     <= '0;
      credit_q   <= CREDIT_MAX;
      fifo_wen_q <= 1'b0;
      fifo_din_q <= '0;
      fifo_src_q <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      owner_q    <= owner_d;
      beat_q     <= beat_d;
      credit_q   <= credit_d;
      fifo_wen_q <= fifo_wen_d;
      fifo_din_q <= fifo_din_d;
      fifo_src_q <= fifo_src_d;
    end
  end

  assign fifo_wen = fifo_wen_q;
  assign fifo_din = fifo_din_q;
  assign fifo_src = fifo_src_q;

`ifdef FIFO_WR_ARB_GNT_CNT_EN
  logic [NREQ-1:0][15:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    for (int i = 0; i < NREQ; i++) begin
      if (req[i] && gnt[i] && cnt_q[i] != 16'hFFFF) cnt_d[i] = cnt_q[i] + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign gnt_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - directed self-checking bench for fifo_wr_arb
module tb_fifo_wr_arb;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [31:0] din;
  logic [3:0]  gnt;
  logic        fifo_pop;
  logic        fifo_wen;
  logic [7:0]  fifo_din;
  logic [1:0]  fifo_src;
`ifdef FIFO_WR_ARB_GNT_CNT_EN
  logic [63:0] gnt_cnt;
`endif

  int n_cmp  = 0;
  int n_fail = 0;
  int n_xfer;

  logic [3:0] exp_g [12] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                             4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                             4'b0100, 4'b0100};

  always #5 clk = ~clk;

  fifo_wr_arb #(.NREQ(4), .DW(8), .DEPTH(8), .BURST_LEN(4)) dut (
    .clk      (clk),
    .reset    (reset),
    .req      (req),
    .din      (din),
    .gnt      (gnt),
    .fifo_pop (fifo_pop),
    .fifo_wen (fifo_wen),
    .fifo_din (fifo_din),
    .fifo_src (fifo_src)
`ifdef FIFO_WR_ARB_GNT_CNT_EN
    ,
    .gnt_cnt  (gnt_cnt)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic reset_pulse();
    reset    = 1'b1;
    req      = '0;
    fifo_pop = 1'b0;
    tick();
    reset    = 1'b0;
  endtask

  function automatic int oh2i(input logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return 0;
  endfunction

  initial begin
    // reset state, with requests pending to show gnt is forced low
    reset    = 1'b1;
    req      = 4'hF;
    din      = '0;
    fifo_pop = 1'b0;
    #2;
    check("rst_gnt",    gnt,           0);
    check("rst_wen",    fifo_wen,      0);
    check("rst_din",    fifo_din,      0);
    check("rst_src",    fifo_src,      0);
    check("rst_credit", dut.credit_q,  8);
    check("rst_ptr",    dut.ptr_q,     0);
    req = '0;
    tick();
    tick();
    reset = 1'b0;

    // single beat from requester 0
    req = 4'b0001;
    din = 32'h000000A5;
    #1;
    check("t1_gnt", gnt, 4'b0001);
    tick();
    check("t1_wen",    fifo_wen,     1);
    check("t1_din",    fifo_din,     8'hA5);
    check("t1_src",    fifo_src,     0);
    check("t1_credit", dut.credit_q, 7);
    req = '0;
    #1;
    check("t1_release_gnt", gnt, 0);
    tick();
    check("t1_wen_off", fifo_wen,     0);
    check("t1_ptr",     dut.ptr_q,    1);
    check("t1_credit2", dut.credit_q, 7);

    // all requesting, reader draining: bursts of 4 with a gap between owners
    reset_pulse();
    din      = 32'h44332211;
    req      = 4'hF;
    fifo_pop = 1'b1;
    #1;
    for (int c = 0; c < 12; c++) begin
      check($sformatf("rr_gnt_%0d", c), gnt, exp_g[c]);
      tick();
      check($sformatf("rr_wen_%0d", c), fifo_wen, (exp_g[c] != 0));
      if (exp_g[c] != 0) begin
        check($sformatf("rr_src_%0d", c), fifo_src, oh2i(exp_g[c]));
        check($sformatf("rr_din_%0d", c), fifo_din, 8'(8'h11 * (oh2i(exp_g[c]) + 1)));
      end
    end
    req      = '0;
    fifo_pop = 1'b0;

    // full boundary: 8 transfers then stall; one pop frees exactly one more
    reset_pulse();
    req = 4'b0001;
    #1;
    n_xfer = 0;
    for (int i = 0; i < 12; i++) begin
      if (gnt[0]) n_xfer++;
      tick();
    end
    check("full_xfers",  n_xfer,       8);
    check("full_gnt",    gnt,          0);
    check("full_credit", dut.credit_q, 0);
    fifo_pop = 1'b1;
    #1;
    check("full_pop_gnt", gnt, 0);
    tick();
    fifo_pop = 1'b0;
    check("full_pop_credit", dut.credit_q, 1);
    #1;
    n_xfer = 0;
    for (int i = 0; i < 6; i++) begin
      if (gnt[0]) n_xfer++;
      tick();
    end
    check("one_more_xfer", n_xfer,       1);
    check("one_more_cred", dut.credit_q, 0);

    // pop and transfer on the same edge at credit 3
    reset_pulse();
    req = 4'b0001;
    #1;
    repeat (6) tick();
    check("c3_pre", dut.credit_q, 3);
    fifo_pop = 1'b1;
    #1;
    check("c3_gnt", gnt, 4'b0001);
    tick();
    fifo_pop = 1'b0;
    check("c3_credit", dut.credit_q, 3);
    check("c3_wen",    fifo_wen,     1);

    // pop while empty is ignored
    reset_pulse();
    fifo_pop = 1'b1;
    tick();
    fifo_pop = 1'b0;
    check("c8_credit", dut.credit_q, 8);
    check("c8_gnt",    gnt,          0);

    // reset during beat 2
    reset_pulse();
    req = 4'b0001;
    din = 32'h0000005A;
    #1;
    tick();
    check("mid_gnt_b2", gnt,      4'b0001);
    check("mid_wen_b1", fifo_wen, 1);
    reset = 1'b1;
    #1;
    check("mid_rst_gnt",    gnt,          0);
    check("mid_rst_wen",    fifo_wen,     0);
    check("mid_rst_credit", dut.credit_q, 8);
    tick();
    check("mid_rst_wen2", fifo_wen, 0);
    reset = 1'b0;
    req   = '0;
    #1;
    check("post_rst_ptr",    dut.ptr_q,    0);
    check("post_rst_credit", dut.credit_q, 8);
    check("post_rst_wen",    fifo_wen,     0);

`ifdef FIFO_WR_ARB_GNT_CNT_EN
    // five transfers from requester 2
    reset_pulse();
    req = 4'b0100;
    #1;
    repeat (6) tick();
    req = '0;
    check("cnt_0", gnt_cnt[15:0],  0);
    check("cnt_1", gnt_cnt[31:16], 0);
    check("cnt_2", gnt_cnt[47:32], 5);
    check("cnt_3", gnt_cnt[63:48], 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
